// File: rtl/voice_alloc_pkg.sv
// Shared constants and FSM encoding for the two-voice note allocator.
package voice_alloc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MATCH  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_NOTIFY = 2'd3
   } state_t;

   localparam int          KEY_BASE_DEF = 48;
   localparam logic [4:0]  IDLE_ID_DEF  = 5'd31;
   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned EV_W         = 8;   // {on, key[6:0]}

endpackage

// File: rtl/voice_fifo.sv
// Small synchronous FIFO; push is ignored when full, pop ignored when empty.
module voice_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/voice_alloc.sv
// Two-voice note allocator: FIFO-buffered note events, retrigger/free/steal/LRU.
// Optional sustain-pedal handling is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
module voice_alloc #(
   parameter int         KEY_BASE = voice_alloc_pkg::KEY_BASE_DEF,
   parameter logic [4:0] IDLE_ID  = voice_alloc_pkg::IDLE_ID_DEF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ev_valid,
   input  logic       ev_on,
   input  logic [6:0] ev_key,
   output logic       ev_ready,
   input  logic       sustain,
   output logic [4:0] freq_id1,
   output logic [4:0] freq_id2,
   output logic [1:0] voice_active,
   output logic       new_f,
   output logic [7:0] drop_cnt
);
   import voice_alloc_pkg::*;

   state_t          state, state_nxt;
   logic            fifo_full, fifo_empty, push, pop;
   logic [EV_W-1:0] fifo_dout;

   logic            cur_on;
   logic [6:0]      cur_key;
   logic            in_range, in_range_r;
   logic [4:0]      fid, fid_r;
   logic [1:0]      match_r;

   logic [1:0][4:0] freq, freq_nxt;
   logic [1:0]      active, active_nxt;
   logic [1:0]      pend, pend_nxt;
   logic            lru, lru_nxt;
   logic            changed, changed_nxt;
   logic [7:0]      drop_nxt;
   logic            tgt;
   logic            sus_eff;
   logic            rel_pend;
   logic            rel_go;

   assign ev_ready     = !fifo_full;
   assign push         = ev_valid && !fifo_full;
   assign freq_id1     = freq[0];
   assign freq_id2     = freq[1];
   assign voice_active = active;

   voice_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (push),
      .pop    (pop),
      .din    ({ev_on, ev_key}),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic sus_q;
   assign sus_eff = sustain;

   // A pedal release seen while the FSM is busy stays pending until IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sus_q    <= 1'b0;
         rel_pend <= 1'b0;
      end else begin
         sus_q <= sustain;
         if (sus_q && !sustain) rel_pend <= 1'b1;
         else if (rel_go)       rel_pend <= 1'b0;
      end
   end
`else
   logic sustain_unused;
   assign sustain_unused = sustain;
   assign sus_eff        = 1'b0;
   assign rel_pend       = 1'b0;
`endif

   assign in_range = (int'(cur_key) >= KEY_BASE) && (int'(cur_key) <= KEY_BASE + 30);
   assign fid      = 5'(cur_key - 7'(KEY_BASE));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      rel_go    = 1'b0;
      new_f     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rel_pend) begin
               rel_go    = 1'b1;
               state_nxt = (|pend) ? ST_NOTIFY : ST_IDLE;
            end else if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_MATCH;
            end
         end
         ST_MATCH:  state_nxt = ST_UPDATE;
         ST_UPDATE: state_nxt = ST_NOTIFY;
         ST_NOTIFY: begin
            new_f     = changed;
            state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Voice-state update; only the UPDATE state or a pedal release change it.
   always_comb begin
      freq_nxt    = freq;
      active_nxt  = active;
      pend_nxt    = pend;
      lru_nxt     = lru;
      changed_nxt = changed;
      drop_nxt    = drop_cnt;
      tgt         = 1'b0;
      if (rel_go) begin
         for (int unsigned v = 0; v < 2; v++) begin
            if (pend[v]) begin
               active_nxt[v] = 1'b0;
               freq_nxt[v]   = IDLE_ID;
            end
         end
         pend_nxt    = '0;
         changed_nxt = |pend;
      end else if (state == ST_UPDATE) begin
         changed_nxt = 1'b0;
         if (!in_range_r) begin
            if (cur_on && drop_cnt != '1) drop_nxt = drop_cnt + 8'd1;
         end else if (cur_on) begin
            changed_nxt = 1'b1;
            if (|match_r)      tgt = !match_r[0];
            else if (!(&active)) tgt = active[0];
            else if (|pend)    tgt = !pend[0];
            else               tgt = lru;
            freq_nxt[tgt]   = fid_r;
            active_nxt[tgt] = 1'b1;
            pend_nxt[tgt]   = 1'b0;
            lru_nxt         = !tgt;
         end else if (|match_r) begin
            if (sus_eff) begin
               pend_nxt = pend | match_r;
            end else begin
               changed_nxt = 1'b1;
               for (int unsigned v = 0; v < 2; v++) begin
                  if (match_r[v]) begin
                     active_nxt[v] = 1'b0;
                     freq_nxt[v]   = IDLE_ID;
                  end
               end
               pend_nxt = pend & ~match_r;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_on     <= 1'b0;
         cur_key    <= '0;
         in_range_r <= 1'b0;
         fid_r      <= '0;
         match_r    <= '0;
         freq       <= {IDLE_ID, IDLE_ID};
         active     <= '0;
         pend       <= '0;
         lru        <= 1'b0;
         changed    <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (pop) {cur_on, cur_key} <= fifo_dout;
         if (state == ST_MATCH) begin
            in_range_r <= in_range;
            fid_r      <= fid;
            for (int unsigned v = 0; v < 2; v++)
               match_r[v] <= in_range && active[v] && (freq[v] == fid);
         end
         freq     <= freq_nxt;
         active   <= active_nxt;
         pend     <= pend_nxt;
         lru      <= lru_nxt;
         changed  <= changed_nxt;
         drop_cnt <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed, table-driven self-checking bench for voice_alloc (KEY_BASE=48, IDLE_ID=31).
module tb_voice_alloc;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ev_valid = 1'b0;
   logic       ev_on = 1'b0;
   logic [6:0] ev_key = '0;
   logic       sustain = 1'b0;
   logic       ev_ready;
   logic [4:0] freq_id1, freq_id2;
   logic [1:0] voice_active;
   logic       new_f;
   logic [7:0] drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [4:0] pf1 = 5'd31, pf2 = 5'd31;
   logic [1:0] pact = 2'b00;
   logic [7:0] pdrop = 8'd0;

   typedef struct {
      bit         on;
      int         key;
      bit         sus;
      logic [4:0] f1;
      logic [4:0] f2;
      logic [1:0] act;
      bit         nf;
      logic [7:0] drop;
   } vec_t;

   vec_t vt [20];

   always #5 clock = ~clock;

   voice_alloc #(.KEY_BASE(48), .IDLE_ID(5'd31)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ev_valid    (ev_valid),
      .ev_on       (ev_on),
      .ev_key      (ev_key),
      .ev_ready    (ev_ready),
      .sustain     (sustain),
      .freq_id1    (freq_id1),
      .freq_id2    (freq_id2),
      .voice_active(voice_active),
      .new_f       (new_f),
      .drop_cnt    (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      ev_valid = 1'b0;
      sustain  = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      pf1 = 5'd31; pf2 = 5'd31; pact = 2'b00; pdrop = 8'd0;
   endtask

   // Offer one event at edge E, then watch negedges after E..E+4.
   task automatic run_vec(input vec_t v, input string tag);
      logic [4:0] hist;
      hist = '0;
      @(negedge clock);
      check({tag, "_ready"}, ev_ready, 1);
      ev_valid = 1'b1;
      ev_on    = v.on;
      ev_key   = 7'(v.key);
      sustain  = v.sus;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (k == 0) ev_valid = 1'b0;
         hist[k] = new_f;
         if (k == 2)
            check({tag, "_pre"}, {freq_id1, freq_id2, voice_active, drop_cnt},
                  {pf1, pf2, pact, pdrop});
         if (k == 3) begin
            check({tag, "_f1"},   freq_id1, v.f1);
            check({tag, "_f2"},   freq_id2, v.f2);
            check({tag, "_act"},  voice_active, v.act);
            check({tag, "_drop"}, drop_cnt, v.drop);
         end
      end
      check({tag, "_newf"}, hist, v.nf ? 5'b01000 : 5'b00000);
      pf1 = v.f1; pf2 = v.f2; pact = v.act; pdrop = v.drop;
   endtask

   initial begin
      int         sent, cyc, pulses, full_at;
      logic       rdy;
      bit         bb_on [6];
      logic [6:0] bb_key [6];
      logic [11:0] snap [$];
      logic [11:0] snap_exp [5];

      //          on  key sus  f1     f2     act    nf  drop
      vt[0]  = '{1, 60, 0, 5'd12, 5'd31, 2'b01, 1, 8'd0};
      vt[1]  = '{1, 64, 0, 5'd12, 5'd16, 2'b11, 1, 8'd0};
      vt[2]  = '{1, 67, 0, 5'd19, 5'd16, 2'b11, 1, 8'd0};
      vt[3]  = '{1, 64, 0, 5'd19, 5'd16, 2'b11, 1, 8'd0};
      vt[4]  = '{1, 50, 0, 5'd2,  5'd16, 2'b11, 1, 8'd0};
      vt[5]  = '{0, 64, 0, 5'd2,  5'd31, 2'b01, 1, 8'd0};
      vt[6]  = '{0, 72, 0, 5'd2,  5'd31, 2'b01, 0, 8'd0};
      vt[7]  = '{1, 40, 0, 5'd2,  5'd31, 2'b01, 0, 8'd1};
      vt[8]  = '{1, 90, 0, 5'd2,  5'd31, 2'b01, 0, 8'd2};
      vt[9]  = '{1, 78, 0, 5'd2,  5'd30, 2'b11, 1, 8'd2};
      vt[10] = '{1, 47, 0, 5'd2,  5'd30, 2'b11, 0, 8'd3};
      vt[11] = '{1, 79, 0, 5'd2,  5'd30, 2'b11, 0, 8'd4};
      vt[12] = '{0, 50, 0, 5'd31, 5'd30, 2'b10, 1, 8'd4};
      vt[13] = '{0, 78, 0, 5'd31, 5'd31, 2'b00, 1, 8'd4};
      vt[14] = '{1, 48, 0, 5'd0,  5'd31, 2'b01, 1, 8'd4};
      vt[15] = '{0, 40, 0, 5'd0,  5'd31, 2'b01, 0, 8'd4};
      vt[16] = '{0, 48, 0, 5'd31, 5'd31, 2'b00, 1, 8'd4};
      vt[17] = '{1, 60, 0, 5'd12, 5'd31, 2'b01, 1, 8'd4};
      vt[18] = '{0, 60, 0, 5'd31, 5'd31, 2'b00, 1, 8'd4};
      vt[19] = '{0, 72, 0, 5'd31, 5'd31, 2'b00, 0, 8'd4};

      // Values while reset is held.
      repeat (2) @(negedge clock);
      check("rst_ready", ev_ready, 1);
      check("rst_f1",    freq_id1, 31);
      check("rst_f2",    freq_id2, 31);
      check("rst_act",   voice_active, 0);
      check("rst_newf",  new_f, 0);
      check("rst_drop",  drop_cnt, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // Asynchronous reset in the middle of an event discards it.
      run_vec('{1, 62, 0, 5'd14, 5'd31, 2'b01, 1, 8'd4}, "pre_rst");
      @(negedge clock);
      ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd64;
      @(negedge clock);
      ev_valid = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_f1",    freq_id1, 31);
      check("mid_rst_act",   voice_active, 0);
      check("mid_rst_drop",  drop_cnt, 0);
      check("mid_rst_ready", ev_ready, 1);
      check("mid_rst_newf",  new_f, 0);
      @(negedge clock);
      reset_n = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge clock);
         if (new_f) pulses++;
      end
      check("mid_rst_pulses", pulses, 0);
      check("mid_rst_act2",   voice_active, 0);
      pf1 = 5'd31; pf2 = 5'd31; pact = 2'b00; pdrop = 8'd0;
      run_vec('{1, 60, 0, 5'd12, 5'd31, 2'b01, 1, 8'd0}, "post_rst");

      // Six back-to-back events.
      do_reset();
      bb_on[0] = 1; bb_key[0] = 7'd60;
      bb_on[1] = 1; bb_key[1] = 7'd62;
      bb_on[2] = 0; bb_key[2] = 7'd60;
      bb_on[3] = 1; bb_key[3] = 7'd65;
      bb_on[4] = 1; bb_key[4] = 7'd67;
      bb_on[5] = 0; bb_key[5] = 7'd62;
      snap_exp[0] = {5'd12, 5'd31, 2'b01};
      snap_exp[1] = {5'd12, 5'd14, 2'b11};
      snap_exp[2] = {5'd31, 5'd14, 2'b10};
      snap_exp[3] = {5'd17, 5'd14, 2'b11};
      snap_exp[4] = {5'd17, 5'd19, 2'b11};
      sent = 0; cyc = 0; full_at = -1;
      while (cyc < 80) begin
         @(negedge clock);
         if (new_f) snap.push_back({freq_id1, freq_id2, voice_active});
         if (!ev_ready && full_at < 0) full_at = sent;
         if (sent < 6) begin
            ev_valid = 1'b1; ev_on = bb_on[sent]; ev_key = bb_key[sent];
         end else begin
            ev_valid = 1'b0;
         end
         rdy = ev_ready;
         @(posedge clock);
         if (sent < 6 && rdy) sent++;
         cyc++;
      end
      @(negedge clock);
      ev_valid = 1'b0;
      check("bb_sent",     sent, 6);
      check("bb_full_at",  full_at, 5);
      check("bb_pulses",   snap.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("bb_snap%0d", i), (i < snap.size()) ? snap[i] : 12'hfff, snap_exp[i]);
      check("bb_final", {freq_id1, freq_id2, voice_active}, {5'd17, 5'd19, 2'b11});

      // 300 out-of-range note-ons: drop counter saturates.
      do_reset();
      sent = 0; cyc = 0; pulses = 0;
      while (sent < 300 && cyc < 5000) begin
         @(negedge clock);
         if (new_f) pulses++;
         ev_valid = 1'b1; ev_on = 1'b1;
         ev_key = (sent % 2 == 1) ? 7'd90 : 7'd40;
         rdy = ev_ready;
         @(posedge clock);
         if (rdy) sent++;
         cyc++;
      end
      @(negedge clock);
      ev_valid = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (new_f) pulses++;
      end
      check("sat_sent",   sent, 300);
      check("sat_drop",   drop_cnt, 255);
      check("sat_pulses", pulses, 0);
      check("sat_state",  {freq_id1, freq_id2, voice_active}, {5'd31, 5'd31, 2'b00});

      // Sustain pedal behaviour.
      do_reset();
`ifdef VOICE_ALLOC_SUSTAIN_EN
      run_vec('{1, 60, 1, 5'd12, 5'd31, 2'b01, 1, 8'd0}, "sus_on");
      run_vec('{0, 60, 1, 5'd12, 5'd31, 2'b01, 0, 8'd0}, "sus_off");
      @(negedge clock);
      sustain = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clock);
         if (new_f) pulses++;
      end
      check("sus_rel_pulses", pulses, 1);
      check("sus_rel_state", {freq_id1, freq_id2, voice_active}, {5'd31, 5'd31, 2'b00});
`else
      run_vec('{1, 60, 1, 5'd12, 5'd31, 2'b01, 1, 8'd0}, "nosus_on");
      run_vec('{0, 60, 1, 5'd31, 5'd31, 2'b00, 1, 8'd0}, "nosus_off");
      @(negedge clock);
      sustain = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clock);
         if (new_f) pulses++;
      end
      check("nosus_rel_pulses", pulses, 0);
      check("nosus_rel_state", {freq_id1, freq_id2, voice_active}, {5'd31, 5'd31, 2'b00});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
